bram_port_arbiter: RTL and testbench

//   Shares the single PL-side BRAM port B (addrb/dinb/doutb/enb/web) between NCH requesters
//   (SIMD lanes, loader, debug). Round-robin arbitration with optional burst lock, registered

---
 rtl/bram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port B between NCH requesters,
// with burst lock, registered port drive and read-return tag routing.
module bram_port_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 13,
    parameter int DW        = 32,
    parameter int BE        = DW / 8,
    parameter int RL        = 1,
    parameter int BURST_MAX = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    lock,
    input  logic [NCH*BE-1:0] we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdata,
    output logic [AW-1:0]     addrb,
    output logic [DW-1:0]     dinb,
    input  logic [DW-1:0]     doutb,
    output logic              enb,
    output logic [BE-1:0]     web,
    output logic              busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(BURST_MAX + 1);

    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] own_q, own_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lkd_q, lkd_d;

    logic [NCH-1:0] lock_eff;
    logic           hold;
    logic           acc;
    logic [IW-1:0]  win;
    logic [IW-1:0]  cand;

    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic [BE-1:0]  sel_we;

    logic           enb_q;
    logic [AW-1:0]  addrb_q;
    logic [DW-1:0]  dinb_q;
    logic [BE-1:0]  web_q;

    logic [RL:0]    vld_q;
    logic [IW-1:0]  ch_q [RL+1];

    // Pick the winner: locked owner outright, else first requester from rr.
    always_comb begin
        lock_eff = (NCH > 1) ? lock : '0;
        hold     = lkd_q && req[own_q] && lock_eff[own_q]
                   && (cnt_q < CW'(BURST_MAX));
        acc      = 1'b0;
        win      = '0;
        cand     = '0;
        if (hold) begin
            acc = 1'b1;
            win = own_q;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cand = IW'((int'(rr_q) + k) % NCH);
                if (!acc && req[cand]) begin
                    acc = 1'b1;
                    win = cand;
                end
            end
        end
    end

    // Next pointer, lock owner and burst count.
    always_comb begin
        rr_d  = rr_q;
        own_d = own_q;
        cnt_d = cnt_q;
        lkd_d = lkd_q;
        if (hold) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            lkd_d = 1'b0;
            cnt_d = '0;
            if (acc) begin
                rr_d = IW'((int'(win) + 1) % NCH);
                if (lock_eff[win]) begin
                    lkd_d = 1'b1;
                    own_d = win;
                    cnt_d = CW'(1);
                end
            end
        end
    end

    // Mux the winning channel's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (win == IW'(k)) begin
                sel_addr  = addr[k*AW +: AW];
                sel_wdata = wdata[k*DW +: DW];
                sel_we    = we[k*BE +: BE];
            end
        end
    end

    // One-hot grant, forced low while reset is asserted.
    always_comb begin
        gnt = '0;
        if (acc && RSTN) gnt[win] = 1'b1;
    end

    // Arbitration state registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rr_q  <= '0;
            own_q <= '0;
            cnt_q <= '0;
            lkd_q <= 1'b0;
        end else begin
            rr_q  <= rr_d;
            own_q <= own_d;
            cnt_q <= cnt_d;
            lkd_q <= lkd_d;
        end
    end

    // Registered BRAM drive; address and data hold when idle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            enb_q   <= 1'b0;
            addrb_q <= '0;
            dinb_q  <= '0;
            web_q   <= '0;
        end else if (acc) begin
            enb_q   <= 1'b1;
            addrb_q <= sel_addr;
            dinb_q  <= sel_wdata;
            web_q   <= sel_we;
        end else begin
            enb_q   <= 1'b0;
            web_q   <= '0;
        end
    end

    // Read tags: stage 0 lines up with enb, stage RL with doutb.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_q <= '0;
            for (int i = 0; i <= RL; i++) ch_q[i] <= '0;
        end else begin
            vld_q[0] <= acc && (sel_we == '0);
            ch_q[0]  <= win;
            for (int i = 1; i <= RL; i++) begin
                vld_q[i] <= vld_q[i-1];
                ch_q[i]  <= ch_q[i-1];
            end
        end
    end

    // Route the returning read to its channel.
    always_comb begin
        rvalid = '0;
        if (vld_q[RL]) rvalid[ch_q[RL]] = 1'b1;
    end

    assign rdata = doutb;
    assign addrb = addrb_q;
    assign dinb  = dinb_q;
    assign enb   = enb_q;
    assign web   = web_q;
    assign busy  = enb_q | (|vld_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: NCH=4/RL=1 and NCH=2/RL=3
// instances, each backed by a write-first BRAM model.
module tb_bram_port_arbiter;

    logic CLK = 1'b0;
    logic RSTN;

    always #5 CLK = ~CLK;

    logic [3:0]   req, lock, gnt, rvalid;
    logic [15:0]  we;
    logic [51:0]  addr;
    logic [127:0] wdata;
    logic [31:0]  rdata, dinb, doutb;
    logic [12:0]  addrb;
    logic         enb, busy;
    logic [3:0]   web;

    logic [1:0]   req2, lock2, gnt2, rvalid2;
    logic [7:0]   we2;
    logic [25:0]  addr2;
    logic [63:0]  wdata2;
    logic [31:0]  rdata2, dinb2, doutb2;
    logic [12:0]  addrb2;
    logic         enb2, busy2;
    logic [3:0]   web2;

    int n_chk  = 0;
    int n_fail = 0;

    bram_port_arbiter u_dut (
        .CLK(CLK), .RSTN(RSTN), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .addrb(addrb), .dinb(dinb), .doutb(doutb),
        .enb(enb), .web(web), .busy(busy)
    );

    bram_port_arbiter #(.NCH(2), .RL(3)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN), .req(req2), .lock(lock2), .we(we2),
        .addr(addr2), .wdata(wdata2), .gnt(gnt2), .rvalid(rvalid2),
        .rdata(rdata2), .addrb(addrb2), .dinb(dinb2), .doutb(doutb2),
        .enb(enb2), .web(web2), .busy(busy2)
    );

    function automatic logic [31:0] pat(input logic [12:0] a);
        return 32'hA500_0000 | {21'b0, a[12:2]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [3:0]  w);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (w[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    logic [31:0] mem1 [2048];
    logic [31:0] mem2 [2048];
    logic [31:0] dq1;
    logic [31:0] p2 [3];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = pat(13'(i << 2));
            mem2[i] = pat(13'(i << 2));
        end
    end

    always @(posedge CLK) begin
        if (enb) begin
            mem1[addrb[12:2]] <= merge(mem1[addrb[12:2]], dinb, web);
            dq1 <= merge(mem1[addrb[12:2]], dinb, web);
        end
    end
    assign doutb = dq1;

    always @(posedge CLK) begin
        if (enb2) begin
            mem2[addrb2[12:2]] <= merge(mem2[addrb2[12:2]], dinb2, web2);
            p2[0] <= merge(mem2[addrb2[12:2]], dinb2, web2);
        end
        p2[1] <= p2[0];
        p2[2] <= p2[1];
    end
    assign doutb2 = p2[2];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [12:0] a,
                          input logic [3:0] w, input logic [31:0] d);
        addr[c*13 +: 13] = a;
        we[c*4 +: 4]     = w;
        wdata[c*32 +: 32] = d;
    endtask

    initial begin
        RSTN = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        req2 = '0; lock2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;

        @(negedge CLK);
        check("reset_state", {gnt, rvalid, addrb, dinb, enb, web, busy}, 64'h0);
        check("reset_state2", {gnt2, rvalid2, enb2, web2, busy2}, 64'h0);
        step();
        RSTN = 1'b1;

        // Round robin, all channels reading every cycle.
        for (int i = 0; i < 4; i++) set_ch(i, 13'(i * 64), 4'h0, 32'h0);
        req = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            check("rr_gnt", gnt, (k < 8) ? (64'h1 << (k % 4)) : 64'h0);
            if (k >= 2 && k < 10) begin
                check("rr_rvalid", rvalid, 64'h1 << ((k - 2) % 4));
                check("rr_rdata", rdata, pat(13'(((k - 2) % 4) * 64)));
            end else begin
                check("rr_rvalid_idle", rvalid, 64'h0);
            end
            step();
            if (k == 7) req = 4'h0;
        end

        // Write then read-after-write on another channel.
        set_ch(1, 13'h010, 4'hF, 32'hDEADBEEF);
        req = 4'b0010;
        @(negedge CLK);
        check("raw_wgnt", gnt, 64'h2);
        step();
        set_ch(2, 13'h010, 4'h0, 32'h0);
        req = 4'b0100;
        @(negedge CLK);
        check("raw_rgnt", gnt, 64'h4);
        check("raw_drive", {enb, web, addrb, dinb},
              {1'b1, 4'hF, 13'h010, 32'hDEADBEEF});
        step();
        req = 4'h0;
        @(negedge CLK);
        check("raw_no_wr_rvalid", rvalid, 64'h0);
        step();
        @(negedge CLK);
        check("raw_rvalid", rvalid, 64'h4);
        check("raw_rdata", rdata, 64'hDEADBEEF);
        step();

        // Partial byte write onto all-ones.
        set_ch(0, 13'h020, 4'hF, 32'hFFFFFFFF);
        req = 4'b0001;
        @(negedge CLK);
        check("pw_g1", gnt, 64'h1);
        step();
        set_ch(0, 13'h020, 4'b0011, 32'h12345678);
        @(negedge CLK);
        check("pw_g2", gnt, 64'h1);
        check("pw_drive_web", web, 64'hF);
        step();
        set_ch(0, 13'h020, 4'h0, 32'h0);
        @(negedge CLK);
        check("pw_g3", gnt, 64'h1);
        check("pw_no_wr_rvalid", rvalid, 64'h0);
        step();
        req = 4'h0;
        @(negedge CLK);
        check("pw_wait", rvalid, 64'h0);
        step();
        @(negedge CLK);
        check("pw_rvalid", rvalid, 64'h1);
        check("pw_rdata", rdata, 64'hFFFF5678);
        step();

        // Fresh reset so the burst starts from pointer 0.
        RSTN = 1'b0;
        step();
        RSTN = 1'b1;

        // Burst lock: 8 owner grants, one forced rotation, owner resumes.
        set_ch(0, 13'h040, 4'h0, 32'h0);
        set_ch(3, 13'h0C0, 4'h0, 32'h0);
        lock = 4'b0001;
        req  = 4'b1001;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            check("lock_gnt", gnt, (k == 8) ? 64'h8 : 64'h1);
            step();
        end
        req = 4'h0;
        lock = 4'h0;
        repeat (3) step();

        // Async reset with two reads in flight.
        set_ch(0, 13'h080, 4'h0, 32'h0);
        lock = 4'b0001;
        req  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("arst_gnt", gnt, 64'h1);
            step();
        end
        RSTN = 1'b0;
        #2;
        check("arst_async", {gnt, rvalid, addrb, dinb, enb, web, busy}, 64'h0);
        @(negedge CLK);
        check("arst_hold", {gnt, rvalid, addrb, dinb, enb, web, busy}, 64'h0);
        step();
        req  = 4'h0;
        lock = 4'h0;
        RSTN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("arst_dropped", {rvalid, busy, enb}, 64'h0);
            step();
        end

        // NCH=2, RL=3: alternating reads, 4-cycle return, busy span.
        addr2[0 +: 13]  = 13'h100;
        addr2[13 +: 13] = 13'h200;
        req2 = 2'b11;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check("rl3_gnt", gnt2, (k < 4) ? (64'h1 << (k % 2)) : 64'h0);
            if (k >= 4 && k < 8) begin
                check("rl3_rvalid", rvalid2, 64'h1 << (k % 2));
                check("rl3_rdata", rdata2,
                      pat((k % 2 == 1) ? 13'h200 : 13'h100));
            end else begin
                check("rl3_rvalid_idle", rvalid2, 64'h0);
            end
            check("rl3_busy", busy2, (k >= 1 && k <= 7) ? 64'h1 : 64'h0);
            step();
            if (k == 3) req2 = 2'b00;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
